// File: rtl/snitch_round_ctrl_pkg.sv
// Shared definitions for the snitch round controller: state codes, grant owners,
// winner codes and the IR grid width.
package snitch_round_ctrl_pkg;

  localparam int unsigned GridW = 16;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StActive    = 3'd2,
    StCaught    = 3'd3,
    StGameover  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnP1   = 2'b01,
    OwnP2   = 2'b10
  } owner_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;
  localparam logic [1:0] WinTie  = 2'b11;

  function automatic logic [1:0] winner_of(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) return WinP1;
    if (s2 > s1) return WinP2;
    return WinTie;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hf) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/snitch_round_ctrl_tick.sv
// One-cycle tick every TICK_DIV clocks; clear restarts the period from zero.
module snitch_round_ctrl_tick #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == Last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/snitch_round_ctrl.sv
// Round controller for the snitch game: countdown, active play with IR arbitration,
// post-catch hold, game timer and winner decision.
module snitch_round_ctrl
  import snitch_round_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned COUNTDOWN_S = 3,
  parameter int unsigned GAME_S      = 60,
  parameter int unsigned HOLD_S      = 2,
  parameter int unsigned WIN_SCORE   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [GridW-1:0] ir_p1,
  input  logic [GridW-1:0] ir_p2,
  input  logic             snitch_caught,
  output logic             snitch_powerup,
  output logic [GridW-1:0] ir_to_snitch,
  output logic [2:0]       state,
  output logic [6:0]       secs_left,
  output logic [3:0]       score_p1,
  output logic [3:0]       score_p2,
  output logic [1:0]       winner
);

  localparam logic [6:0] CountdownS = 7'(COUNTDOWN_S);
  localparam logic [6:0] GameS      = 7'(GAME_S);
  localparam logic [6:0] HoldS      = 7'(HOLD_S);
  localparam logic [3:0] WinScore   = 4'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [6:0]       phase_q, phase_d;
  logic [6:0]       game_q, game_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic [1:0]       winner_q, winner_d;
  logic             rr_q, rr_d;
  logic [GridW-1:0] ir_q, ir_d;
  owner_e           owner_q, owner_d;
  logic             tick, credit_p1, credit_p2;

  snitch_round_ctrl_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state_d != state_q),
    .tick (tick)
  );

  // Catches credit whichever player owned the grid driven last cycle.
  assign credit_p1 = snitch_caught && (state_q == StActive) && (owner_q == OwnP1);
  assign credit_p2 = snitch_caught && (state_q == StActive) && (owner_q == OwnP2);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    game_d   = game_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    unique case (state_q)
      StIdle, StGameover: begin
        if (start) begin
          state_d  = StCountdown;
          phase_d  = CountdownS;
          game_d   = GameS;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WinNone;
        end
      end
      StCountdown: begin
        if (tick) begin
          if (phase_q <= 7'd1) begin
            state_d = StActive;
            phase_d = 7'd0;
          end else begin
            phase_d = phase_q - 7'd1;
          end
        end
      end
      StActive: begin
        if (credit_p1) score1_d = sat_inc(score1_q);
        if (credit_p2) score2_d = sat_inc(score2_q);
        if (tick && game_q <= 7'd1) begin
          // Expiry wins over the hold, but a same-cycle catch is already counted.
          game_d   = 7'd0;
          state_d  = StGameover;
          winner_d = winner_of(score1_d, score2_d);
        end else begin
          if (tick) game_d = game_q - 7'd1;
          if (credit_p1 || credit_p2) begin
            state_d = StCaught;
            phase_d = HoldS;
          end
        end
      end
      StCaught: begin
        if (tick) begin
          if (phase_q <= 7'd1) begin
            if (score1_q >= WinScore || score2_q >= WinScore) begin
              state_d  = StGameover;
              phase_d  = 7'd0;
              winner_d = winner_of(score1_q, score2_q);
            end else begin
              state_d = StCountdown;
              phase_d = CountdownS;
            end
          end else begin
            phase_d = phase_q - 7'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grants are only registered while play continues, so the grid drops on the edge
  // that leaves ACTIVE and a stale owner never survives into a later ACTIVE period.
  always_comb begin
    ir_d    = '0;
    owner_d = OwnNone;
    rr_d    = rr_q;
    if (state_q == StActive && state_d == StActive) begin
      if ((|ir_p1) && (|ir_p2)) begin
        ir_d    = rr_q ? ir_p2 : ir_p1;
        owner_d = rr_q ? OwnP2 : OwnP1;
        rr_d    = ~rr_q;
      end else if (|ir_p1) begin
        ir_d    = ir_p1;
        owner_d = OwnP1;
      end else if (|ir_p2) begin
        ir_d    = ir_p2;
        owner_d = OwnP2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= 7'd0;
      game_q   <= 7'd0;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      winner_q <= WinNone;
      rr_q     <= 1'b0;
      ir_q     <= '0;
      owner_q  <= OwnNone;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      game_q   <= game_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      ir_q     <= ir_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    secs_left = 7'd0;
    unique case (state_q)
      StActive:              secs_left = game_q;
      StCountdown, StCaught: secs_left = phase_q;
      default:               secs_left = 7'd0;
    endcase
  end

  assign snitch_powerup = (state_q == StActive);
  assign ir_to_snitch   = ir_q;
  assign state          = state_q;
  assign score_p1       = score1_q;
  assign score_p2       = score2_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_snitch_round_ctrl.sv
// Directed bench for snitch_round_ctrl with a 4-cycle tick and short game timings.
module tb_snitch_round_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir_p1 = '0;
  logic [15:0] ir_p2 = '0;
  logic        snitch_caught = 1'b0;
  logic        snitch_powerup;
  logic [15:0] ir_to_snitch;
  logic [2:0]  state;
  logic [6:0]  secs_left;
  logic [3:0]  score_p1, score_p2;
  logic [1:0]  winner;

  int checks = 0;
  int failures = 0;

  snitch_round_ctrl #(
    .TICK_DIV(4), .COUNTDOWN_S(2), .GAME_S(10), .HOLD_S(1), .WIN_SCORE(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ir_p1(ir_p1), .ir_p2(ir_p2),
    .snitch_caught(snitch_caught), .snitch_powerup(snitch_powerup),
    .ir_to_snitch(ir_to_snitch), .state(state), .secs_left(secs_left),
    .score_p1(score_p1), .score_p2(score_p2), .winner(winner)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(2);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL reset_secs got=%0d exp=0", secs_left); end
    checks++; if ({score_p1, score_p2, winner} !== 10'd0) begin failures++; $display("FAIL reset_scores got=%0h exp=0", {score_p1, score_p2, winner}); end
    checks++; if ({snitch_powerup, ir_to_snitch} !== 17'd0) begin failures++; $display("FAIL reset_outs got=%0h exp=0", {snitch_powerup, ir_to_snitch}); end
    reset = 1'b0;
    step(1);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  // Start pulse, then check countdown values and ACTIVE entry 8 cycles later.
  task automatic test_countdown;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (state !== 3'd1 || secs_left !== 7'd2) begin failures++; $display("FAIL cd_entry got=%0d/%0d exp=1/2", state, secs_left); end
    step(3);
    checks++; if (secs_left !== 7'd2) begin failures++; $display("FAIL cd_hold2 got=%0d exp=2", secs_left); end
    step(1);
    checks++; if (secs_left !== 7'd1) begin failures++; $display("FAIL cd_sec1 got=%0d exp=1", secs_left); end
    step(3);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL cd_still got=%0d exp=1", state); end
    step(1);
    checks++; if (state !== 3'd2 || snitch_powerup !== 1'b1 || secs_left !== 7'd10) begin failures++; $display("FAIL active_entry got=%0d/%0b/%0d exp=2/1/10", state, snitch_powerup, secs_left); end
  endtask

  task automatic test_single_catch;
    ir_p1 = 16'h0020;
    step(1);
    checks++; if (ir_to_snitch !== 16'h0020) begin failures++; $display("FAIL grant_p1 got=%h exp=0020", ir_to_snitch); end
    ir_p1 = 16'h0;
    snitch_caught = 1'b1;
    step(1);
    snitch_caught = 1'b0;
    checks++; if (state !== 3'd3 || score_p1 !== 4'd1 || snitch_powerup !== 1'b0) begin failures++; $display("FAIL catch1 got=%0d/%0d/%0b exp=3/1/0", state, score_p1, snitch_powerup); end
    checks++; if (ir_to_snitch !== 16'h0 || secs_left !== 7'd1) begin failures++; $display("FAIL caught_outs got=%h/%0d exp=0000/1", ir_to_snitch, secs_left); end
    step(4);
    checks++; if (state !== 3'd1 || secs_left !== 7'd2) begin failures++; $display("FAIL hold_to_cd got=%0d/%0d exp=1/2", state, secs_left); end
    step(8);
    checks++; if (state !== 3'd2 || secs_left !== 7'd10) begin failures++; $display("FAIL timer_kept got=%0d/%0d exp=2/10", state, secs_left); end
  endtask

  task automatic test_contested;
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0001;
    ir_p1 = 16'h0001;
    ir_p2 = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (ir_to_snitch !== exp_seq[i]) begin failures++; $display("FAIL rr_%0d got=%h exp=%h", i, ir_to_snitch, exp_seq[i]); end
    end
    ir_p1 = 16'h0;
    ir_p2 = 16'h0;
    step(1);
    checks++; if (ir_to_snitch !== 16'h0 || secs_left !== 7'd9) begin failures++; $display("FAIL idle_grid got=%h/%0d exp=0000/9", ir_to_snitch, secs_left); end
  endtask

  // Two P2 catches; P1 already holds one, so the second P2 catch reaches WIN_SCORE.
  task automatic test_p2_wins;
    for (int k = 0; k < 2; k++) begin
      ir_p2 = 16'h0100;
      step(1);
      ir_p2 = 16'h0;
      snitch_caught = 1'b1;
      step(1);
      snitch_caught = 1'b0;
      checks++; if (state !== 3'd3 || score_p2 !== 4'(k + 1)) begin failures++; $display("FAIL p2_catch%0d got=%0d/%0d exp=3/%0d", k, state, score_p2, k + 1); end
      if (k == 0) step(12);
    end
    step(3);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL hold_len got=%0d exp=3", state); end
    step(1);
    checks++; if (state !== 3'd4 || winner !== 2'b10 || snitch_powerup !== 1'b0) begin failures++; $display("FAIL p2_win got=%0d/%b/%0b exp=4/10/0", state, winner, snitch_powerup); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (state !== 3'd1 || {score_p1, score_p2, winner} !== 10'd0) begin failures++; $display("FAIL restart got=%0d/%0h exp=1/0", state, {score_p1, score_p2, winner}); end
  endtask

  task automatic test_timeout;
    step(8);
    checks++; if (state !== 3'd2 || secs_left !== 7'd10) begin failures++; $display("FAIL to_active got=%0d/%0d exp=2/10", state, secs_left); end
    step(39);
    checks++; if (state !== 3'd2 || secs_left !== 7'd1) begin failures++; $display("FAIL to_last got=%0d/%0d exp=2/1", state, secs_left); end
    step(1);
    checks++; if (state !== 3'd4 || winner !== 2'b11) begin failures++; $display("FAIL tie got=%0d/%b exp=4/11", state, winner); end
    snitch_caught = 1'b1;
    step(1);
    snitch_caught = 1'b0;
    checks++; if ({score_p1, score_p2} !== 8'd0 || state !== 3'd4) begin failures++; $display("FAIL ignore_go got=%0h/%0d exp=0/4", {score_p1, score_p2}, state); end
  endtask

  task automatic test_expiry_catch;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    step(38);
    ir_p1 = 16'h8000;
    step(1);
    ir_p1 = 16'h0;
    checks++; if (ir_to_snitch !== 16'h8000 || secs_left !== 7'd1) begin failures++; $display("FAIL exp_grant got=%h/%0d exp=8000/1", ir_to_snitch, secs_left); end
    snitch_caught = 1'b1;
    step(1);
    snitch_caught = 1'b0;
    checks++; if (state !== 3'd4 || score_p1 !== 4'd1 || winner !== 2'b01) begin failures++; $display("FAIL exp_catch got=%0d/%0d/%b exp=4/1/01", state, score_p1, winner); end
  endtask

  task automatic test_mid_reset;
    start = 1'b1;
    step(1);
    start = 1'b0;
    snitch_caught = 1'b1;
    step(1);
    snitch_caught = 1'b0;
    checks++; if (score_p1 !== 4'd0 || state !== 3'd1) begin failures++; $display("FAIL ignore_cd got=%0d/%0d exp=0/1", score_p1, state); end
    step(7);
    ir_p1 = 16'h0004;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++; if (state !== 3'd2 || ir_to_snitch !== 16'h0004) begin failures++; $display("FAIL start_ign got=%0d/%h exp=2/0004", state, ir_to_snitch); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || snitch_powerup !== 1'b0 || ir_to_snitch !== 16'h0 || secs_left !== 7'd0) begin failures++; $display("FAIL async_rst got=%0d/%0b/%h/%0d exp=0/0/0000/0", state, snitch_powerup, ir_to_snitch, secs_left); end
    ir_p1 = 16'h0;
    step(1);
    reset = 1'b0;
    step(1);
    checks++; if (state !== 3'd0 || winner !== 2'b00) begin failures++; $display("FAIL post_rst got=%0d/%b exp=0/00", state, winner); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_single_catch();
    test_contested();
    test_p2_wins();
    test_timeout();
    test_expiry_catch();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snitch_round_ctrl.md
SNITCH_ROUND_CTRL -- requirements
Module: snitch_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, 50000000, clk cycles per one-second tick.
REQ-002 Parameter COUNTDOWN_S, 3, pre-round countdown in seconds.
REQ-003 Parameter GAME_S, 60, total active game time in seconds.
REQ-004 Parameter HOLD_S, 2, post-catch freeze in seconds.
REQ-005 Parameter WIN_SCORE, 3, catches needed to win outright (1..15).
REQ-006 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-high reset.
REQ-008 Port start, input, 1, level sampled per cycle; begins a game from IDLE or GAMEOVER.
REQ-009 Port ir_p1, input, 16, player-1 IR grid hits, one bit per 4x4 board cell.
REQ-010 Port ir_p2, input, 16, player-2 IR grid hits, same cell mapping.
REQ-011 Port snitch_caught, input, 1, catch flag from the snitch block; reflects the ir_to_snitch value of the previous cycle.
REQ-012 Port snitch_powerup, output, 1, enables snitch motion and catch logic.
REQ-013 Port ir_to_snitch, output, 16, arbitrated IR grid driven to the snitch.
REQ-014 Port state, output, 3, current FSM state code.
REQ-015 Port secs_left, output, 7, seconds remaining in current timed state.
REQ-016 Port score_p1, output, 4, player-1 catches; score_p2, output, 4, player-2 catches.
REQ-017 Port winner, output, 2, 00 none, 01 P1, 10 P2, 11 tie.

Function
REQ-018 FSM states IDLE=0, COUNTDOWN=1, ACTIVE=2, CAUGHT=3, GAMEOVER=4.
REQ-019 Tick generator pulses one cycle every TICK_DIV cycles; its counter clears on every state change.
REQ-020 IDLE/GAMEOVER + start=1 -> COUNTDOWN; scores, winner cleared; game timer loaded GAME_S; start ignored in other states.
REQ-021 COUNTDOWN: secs_left loads COUNTDOWN_S, decrements per tick; on tick at 1 -> ACTIVE.
REQ-022 ACTIVE: snitch_powerup=1; secs_left shows game timer, decremented per tick, persists across CAUGHT/COUNTDOWN re-entries.
REQ-023 Arbitration (ACTIVE only): only one of ir_p1/ir_p2 nonzero -> grant that player; both nonzero -> grant rr pointer player, pointer toggles after each contested grant; both zero -> no grant, ir_to_snitch=0.
REQ-024 ir_to_snitch and grant owner are registered: 1-cycle latency from ir_pX to ir_to_snitch.
REQ-025 snitch_caught=1 in ACTIVE credits owner registered one cycle earlier; no owner -> catch ignored.
REQ-026 Credited score increments, saturates at 15; state -> CAUGHT.
REQ-027 CAUGHT: snitch_powerup=0, ir_to_snitch=0, game timer frozen; secs_left loads HOLD_S, decrements per tick; on tick at 1 -> GAMEOVER if any score >= WIN_SCORE, else COUNTDOWN.
REQ-028 Game timer tick at 1 in ACTIVE -> GAMEOVER; same-cycle catch credited first.
REQ-029 Entry to GAMEOVER sets winner: higher score wins, equal -> 11; snitch_powerup=0.
REQ-030 snitch_caught outside ACTIVE ignored.

Reset
REQ-031 reset asserts asynchronously: state=IDLE, all counters, scores, rr pointer (P1 first), secs_left, winner, ir_to_snitch, snitch_powerup = 0.
REQ-032 Reset mid-game discards scores; first post-reset cycle obeys IDLE rules.

Structure
REQ-033 Shared package holds state codes, winner codes, grid width 16.
REQ-034 One sub-module, tick_gen (parameter TICK_DIV; clear input; tick output).

Verification (TICK_DIV=4, COUNTDOWN_S=2, GAME_S=10, HOLD_S=1, WIN_SCORE=2)
REQ-035 Reset, start pulse -> COUNTDOWN, secs_left 2,1 at 4-cycle steps, ACTIVE after 8 cycles, powerup=1.
REQ-036 ACTIVE, ir_p1=0x0020 only -> ir_to_snitch=0x0020 next cycle; snitch_caught next -> score_p1=1, CAUGHT, powerup=0.
REQ-037 ir_p1=0x0001, ir_p2=0x0002 held -> ir_to_snitch alternates 0x0001,0x0002,0x0001.
REQ-038 Two P2 credited catches -> GAMEOVER after hold, winner=10; start -> scores 0, COUNTDOWN.
REQ-039 No catches for 10 ticks of ACTIVE -> GAMEOVER, winner=11; catch on expiry cycle -> winner credited player.
REQ-040 reset asserted mid-ACTIVE between edges -> outputs 0 immediately, IDLE.
